// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I core.
// The fetch stage and its buffers pick up their width and reset defaults from this package.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush.
// The head entry is visible combinationally; pushes when full and pops when empty are ignored.
module riscv_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_fetch_stage.sv
// IF stage plus IF/ID register: issues PCF to a variable-latency in-order instruction memory,
// buffers returned words, drops wrong-path responses after a redirect and feeds decode.
module riscv_fetch_stage #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  import riscv_pkg::*;

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CRW = CW + 1;
  localparam int BW  = XLEN + 32;

  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] target_aligned;
  logic            issue_en;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CRW-1:0]  credit_used;
  logic            accept;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            buf_pop;

  logic [XLEN-1:0] rsp_pc;
  logic            addr_empty;
  logic            addr_full;
  logic [CW-1:0]   addr_count;

  logic [BW-1:0]   buf_head;
  logic            buf_empty;
  logic            buf_full;
  logic [CW-1:0]   buf_count;

  // Request handshake: a request transfers on a cycle where imem_req_valid and imem_req_ready
  // are both high; valid never depends on ready. Responses carry no ready and return strictly
  // in request order, one per cycle, at least one cycle after their request transferred.
  assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = issue_en && !StallF && !PCSrcE && (credit_used < CRW'(DEPTH));
  assign imem_req_addr  = pcf;
  assign accept         = imem_req_valid && imem_req_ready;

  assign target_aligned = PCTargetE & ~XLEN'(3);
  assign rsp_drop       = imem_rsp_valid && (PCSrcE || (drop_cnt != '0));
  assign rsp_keep       = imem_rsp_valid && !rsp_drop;
  assign buf_pop        = !FlushD && !StallD && !buf_empty;

  // Holds off the first request until the cycle after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_en <= 1'b0;
    end else begin
      issue_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf <= RESET_PC;
    end else if (PCSrcE) begin
      pcf <= target_aligned;
    end else if (accept) begin
      pcf <= pcf + XLEN'(4);
    end
  end

  // Every in-flight request at redirect time is wrong-path; a response landing in the
  // redirect cycle itself is dropped directly and so is not counted again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (PCSrcE) begin
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_req_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pcf),
    .pop       (imem_rsp_valid),
    .head      (rsp_pc),
    .empty     (addr_empty),
    .full      (addr_full),
    .count     (addr_count)
  );

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_instr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (PCSrcE),
    .push      (rsp_keep),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (buf_pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (!buf_empty) begin
      InstrD   <= buf_head[31:0];
      PCD      <= buf_head[BW-1:32];
      PCPlus4D <= buf_head[BW-1:32] + XLEN'(4);
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0))
    else $error("instruction response with no request outstanding");

  req_pc_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    (addr_count == outstanding) && !(accept && addr_full) && !(imem_rsp_valid && addr_empty))
    else $error("request-PC FIFO out of step with outstanding count");

  buf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !buf_full)
    else $error("instruction buffer written while full");
`endif

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: in-order memory model with configurable latency/ready,
// redirect vector table, directed corner sequences and a randomized phase.
module tb_riscv_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        pcsrc_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  riscv_fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .StallF         (stall_f),
    .StallD         (stall_d),
    .FlushD         (flush_d),
    .PCSrcE         (pcsrc_e),
    .PCTargetE      (pc_target_e),
    .imem_req_valid (req_valid),
    .imem_req_ready (req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .InstrD         (instr_d),
    .PCD            (pc_d),
    .PCPlus4D       (pc_plus4_d),
    .ValidD         (valid_d)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- models and scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_ent_t;

  typedef struct {
    logic [31:0] target;
    logic        stall_f;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } redir_vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  mem_ent_t    mem_q[$];
  int          mem_lat = 1;
  int          ready_pct = 100;
  logic [31:0] exp_q[$];        // correct-path PCs owed to decode, program order
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] acc_log[$];
  int          first_acc_cyc = -1;
  int          first_valid_cyc = -1;
  redir_vec_t  vecs[5];

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1: drives memory response and ready for this cycle,
  // updates the models for the coming edge, then checks the IF/ID result after it.
  task automatic step();
    mem_ent_t    e;
    logic [31:0] h_instr, h_pc, h_pc4, want;
    logic        h_valid, p_stall, p_flush;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      e = mem_q.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = tag(e.addr);
    end
    req_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (stall_f || pcsrc_e) check("req_blocked", 32'(req_valid), 32'd0);
    if (req_valid && req_ready) begin
      check("req_addr", req_addr, exp_fetch);
      e.addr = req_addr;
      e.due  = cyc + mem_lat;
      mem_q.push_back(e);
      exp_q.push_back(exp_fetch);
      acc_log.push_back(req_addr);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      exp_fetch = exp_fetch + 32'd4;
      check("outstanding_max", 32'(mem_q.size() <= DEPTH), 32'd1);
    end
    if (pcsrc_e) begin
      exp_fetch = pc_target_e & ~32'h3;
      exp_q.delete();
    end
    h_instr = instr_d; h_pc = pc_d; h_pc4 = pc_plus4_d; h_valid = valid_d;
    p_stall = stall_d; p_flush = flush_d;
    @(posedge clk);
    cyc++;
    #1;
    if (p_flush) begin
      check("flush_valid", 32'(valid_d), 32'd0);
      check("flush_instr", instr_d, NOP);
    end else if (p_stall) begin
      check("hold_instr", instr_d, h_instr);
      check("hold_pc", pc_d, h_pc);
      check("hold_pc4", pc_plus4_d, h_pc4);
      check("hold_valid", 32'(valid_d), 32'(h_valid));
    end else if (valid_d) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL d_extra: got pc %h instr %h, expected no instruction", pc_d, instr_d);
      end else begin
        want = exp_q.pop_front();
        check("d_pc", pc_d, want);
        check("d_instr", instr_d, tag(want));
        check("d_pc4", pc_plus4_d, want + 32'd4);
      end
    end else begin
      check("bubble_instr", instr_d, NOP);
      check("bubble_pc_hold", pc_d, h_pc);
    end
  endtask

  task automatic clear_ctrl();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pcsrc_e = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_ctrl();
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    mem_q.delete();
    exp_q.delete();
    acc_log.delete();
    exp_fetch = 32'h0;
    first_acc_cyc = -1;
    first_valid_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_instr", instr_d, NOP);
    check("rst_pc", pc_d, 32'h0);
    check("rst_pc4", pc_plus4_d, 32'h0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  // Stop fetching and let everything in flight reach decode.
  task automatic drain(input string name);
    clear_ctrl();
    stall_f = 1'b1;
    repeat (16) step();
    stall_f = 1'b0;
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_mem_idle"}, 32'(mem_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int guard;

    vecs[0] = '{target: 32'h0000_0100, stall_f: 1'b0, exp_first: 32'h0000_0100, exp_second: 32'h0000_0104};
    vecs[1] = '{target: 32'h0000_0203, stall_f: 1'b1, exp_first: 32'h0000_0200, exp_second: 32'h0000_0204};
    vecs[2] = '{target: 32'hFFFF_FFFC, stall_f: 1'b0, exp_first: 32'hFFFF_FFFC, exp_second: 32'h0000_0000};
    vecs[3] = '{target: 32'hFFFF_FFFF, stall_f: 1'b1, exp_first: 32'hFFFF_FFFC, exp_second: 32'h0000_0000};
    vecs[4] = '{target: 32'h0000_0007, stall_f: 1'b0, exp_first: 32'h0000_0004, exp_second: 32'h0000_0008};

    // Reset release with a 1-cycle memory.
    apply_reset();
    mem_lat = 1;
    ready_pct = 100;
    repeat (10) step();
    check("first_req0", acc_log[0], 32'h0);
    check("first_req1", acc_log[1], 32'h4);
    check("first_req2", acc_log[2], 32'h8);
    // The accept edge closes cycle first_acc_cyc.
    check("first_valid_latency", 32'(first_valid_cyc - (first_acc_cyc + 1)), 32'd2);

    // Latency-3 memory.
    mem_lat = 3;
    repeat (40) step();
    drain("lat3");

    // StallD long enough for the buffer to fill.
    mem_lat = 1;
    repeat (4) step();
    stall_d = 1'b1;
    repeat (6) step();
    check("full_no_issue", 32'(req_valid), 32'd0);
    stall_d = 1'b0;
    repeat (12) step();
    drain("stalld");

    // Redirect with two requests in flight.
    mem_lat = 3;
    guard = 0;
    while (mem_q.size() < 2 && guard < 20) begin step(); guard++; end
    check("two_in_flight", 32'(mem_q.size()), 32'd2);
    pcsrc_e = 1'b1; flush_d = 1'b1; pc_target_e = 32'h0000_0100;
    step();
    clear_ctrl();
    guard = 0;
    while (!valid_d && guard < 30) begin step(); guard++; end
    check("redirect_first_valid", 32'(valid_d), 32'd1);
    check("redirect_first_pc", pc_d, 32'h0000_0100);
    drain("redirect");

    // Redirect vectors, each issued in a cycle that also carries a response.
    mem_lat = 1;
    for (int v = 0; v < 5; v++) begin
      guard = 0;
      while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && guard < 10) begin step(); guard++; end
      acc_log.delete();
      stall_f = vecs[v].stall_f; pcsrc_e = 1'b1; flush_d = 1'b1; pc_target_e = vecs[v].target;
      step();
      clear_ctrl();
      guard = 0;
      while (acc_log.size() < 2 && guard < 30) begin step(); guard++; end
      if (acc_log.size() < 2) begin
        n_cmp++;
        n_err++;
        $display("FAIL vec%0d_timeout: got %0d requests, expected 2", v, acc_log.size());
      end else begin
        check($sformatf("vec%0d_first", v), acc_log[0], vecs[v].exp_first);
        check($sformatf("vec%0d_second", v), acc_log[1], vecs[v].exp_second);
      end
      repeat (4) step();
    end
    drain("vectors");

    // Randomized traffic.
    ready_pct = 70;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      stall_f     = ($urandom_range(99) < 20);
      stall_d     = ($urandom_range(99) < 20);
      pcsrc_e     = ($urandom_range(99) < 4);
      flush_d     = pcsrc_e || ($urandom_range(99) < 3);
      pc_target_e = $urandom();
      step();
    end
    ready_pct = 100;
    drain("random");

    // Asynchronous reset in the middle of traffic.
    mem_lat = 2;
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_d), 32'd0);
    check("async_rst_instr", instr_d, NOP);
    check("async_rst_req", 32'(req_valid), 32'd0);
    @(posedge clk);
    #1;
    apply_reset();
    repeat (20) step();
    check("post_rst_first_req", acc_log[0], 32'h0);
    drain("post_reset");

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
